// File: rtl/instr_encoder_if.sv
// Field-set / encoded-word bus for instr_encoder.
// The master side supplies decoded fields and consumes encoded words;
// the slave side (the encoder) accepts fields and produces words.
interface instr_encoder_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [WIDTH-1:0]      in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_instr;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_err;
    logic [7:0]            err_count;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RISC-V fields into 32-bit instruction words with a single
// registered output stage, an auto-incrementing byte address and an error
// flag (with saturating error counter) for unencodable requests.
module instr_encoder #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    instr_encoder_if.slave  bus
);
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_REG   = 7'h33;

    localparam logic [WIDTH-1:0]      NOP_WORD  = WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

    logic                  fits12;
    logic                  fits13;
    logic                  in_fire;
    logic                  out_fire;
    logic [WIDTH-1:0]      enc_instr;
    logic                  enc_err;
    logic [ADDR_WIDTH-1:0] addr_cnt;

    // An immediate fits N signed bits when every bit above N-2 equals the sign.
    assign fits12 = (&bus.in_imm[WIDTH-1:11]) || !(|bus.in_imm[WIDTH-1:11]);
    assign fits13 = (&bus.in_imm[WIDTH-1:12]) || !(|bus.in_imm[WIDTH-1:12]);

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = bus.out_valid && bus.out_ready;

    // Format selection and legality check; anything unencodable becomes a NOP.
    always_comb begin
        enc_instr = NOP_WORD;
        enc_err   = 1'b1;
        case (bus.in_opcode)
            OP_IMM: begin
                if (fits12) begin
                    enc_instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                                 bus.in_rd, bus.in_opcode};
                    enc_err   = 1'b0;
                end
            end
            OP_STORE: begin
                if (fits12) begin
                    enc_instr = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                                 bus.in_funct3, bus.in_imm[4:0], bus.in_opcode};
                    enc_err   = 1'b0;
                end
            end
            OP_BR: begin
                if (fits13 && !bus.in_imm[0]) begin
                    enc_instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                                 bus.in_rs1, bus.in_funct3, bus.in_imm[4:1],
                                 bus.in_imm[11], bus.in_opcode};
                    enc_err   = 1'b0;
                end
            end
            OP_REG: begin
                enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                             bus.in_funct3, bus.in_rd, bus.in_opcode};
                enc_err   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Output register: load on input handshake, retire on a lone output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_addr  <= '0;
            bus.out_err   <= 1'b0;
        end else if (in_fire) begin
            bus.out_valid <= 1'b1;
            bus.out_instr <= enc_instr;
            bus.out_addr  <= addr_cnt;
            bus.out_err   <= enc_err;
        end else if (out_fire) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Next-word address; clear wins over the increment and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
        end else if (clear) begin
            addr_cnt <= '0;
        end else if (in_fire) begin
            addr_cnt <= addr_cnt + ADDR_STEP;
        end
    end

    // Saturating count of error words loaded into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_count <= 8'd0;
        end else if (in_fire && enc_err && (bus.err_count != 8'hFF)) begin
            bus.err_count <= bus.err_count + 8'd1;
        end
    end
endmodule
